instruction_trace_buffer: RTL and testbench
===========================================

// Module: instruction_trace_buffer
// PURPOSE
//   Downstream debug consumer of the single-cycle CPU's retired (pcOut, instruction) pair.
//   Each clock one instruction retires; this block captures pairs into a FIFO, with an
//   optional PC-match trigger and capture limit. It drains them through a valid/ready
//   stream to a host/display stage. The block is purely an observer and never stalls the CPU.
// PARAMETERS
//   DEPTH   16  FIFO entries (power of two, >=2)
//   ADDR_W  4   log2(DEPTH)
// PORTS
//   clk            in   1   clock, rising edge
//   rst            in   1   asynchronous, active-high reset
//   pc             in   32  CPU pcOut of instruction retiring this cycle
//   instruction    in   32  CPU instruction at pc
//   start          in   1   pulse: arm/begin capture (honoured only in IDLE or DONE)
//   stop           in   1   pulse: end capture (CAPTURE/ARMED -> DONE)
//   clear          in   1   sync flush: FIFO empty, sticky flags/counters zero, -> IDLE
//   triggerEnable  in   1   sampled on start: 1 = wait for triggerPc, 0 = capture immediately
//   triggerPc      in   32  PC that starts capture when armed
//   captureLimit   in   16  entries to accept before auto-DONE; 0 = unlimited
//   outValid       out  1   FIFO head valid
//   outReady       in   1   consumer accepts head
//   outPc          out  32  head pc
//   outInstr       out  32  head instruction
//   level          out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
//   overflow       out  1   sticky: an entry was dropped because FIFO full
//   droppedCount   out  16  dropped entries, saturates at 16'hFFFF
//   busy           out  1   state is ARMED or CAPTURE
// BEHAVIOUR
//   Reset (rst=1, async): state IDLE, FIFO empty, outValid=0, outPc=outInstr=0, level=0,
//     overflow=0, droppedCount=0, busy=0, accepted-count=0.
//   FSM: IDLE --start--> ARMED (triggerEnable=1) or CAPTURE (triggerEnable=0); accepted-count := 0.
//     ARMED: on edge where pc==triggerPc, that same pair is pushed; -> CAPTURE.
//     CAPTURE: push (pc,instruction) every clock.
//       -> DONE when accepted-count reaches captureLimit (limit!=0), or on stop.
//     DONE: no pushes; start -> re-arm as from IDLE (FIFO contents kept).
//     ARMED --stop--> DONE. clear overrides all (any state -> IDLE); clear beats start/stop.
//   Start latency: a start edge itself does not capture; the first push is on the next edge.
//   stop beats push: the pair present on the stop edge is not captured.
//   Push accepted iff FIFO not full OR a pop occurs on the same edge (full+pop+push: level stays DEPTH).
//   Rejected push: entry lost, overflow:=1, droppedCount++ (saturating); it does not count toward the limit.
//   Only accepted pushes increment accepted-count; entry for the final pair is written on the limit edge.
//   Pop: outValid && outReady at edge; head advances. outValid = (level!=0); outPc/outInstr show
//     head combinationally from storage (show-ahead), 0 when empty is not required.
//   Simultaneous push+pop when empty: push written, pop ignored (outValid was 0); level=1.
//   Pointers wrap modulo DEPTH; level uses ADDR_W+1 bits to distinguish full from empty.
//   clear does not flush on the same edge as a pop: clear wins, FIFO empty next cycle.
//   Reset mid-capture: everything returns to reset values immediately; captured data lost.
// TESTING
//   1 start(triggerEnable=0,limit=3), pc 0,4,8,12 -> entries (0,.)(4,.)(8,.) then DONE; 12 not stored; level=3.
//   2 triggerEnable=1,triggerPc=0x10, pc 0..0x1C step 4, limit=0 -> first entry pc=0x10; busy=1 until stop.
//   3 DEPTH=16, outReady=0, capture 20 cycles -> level=16, overflow=1, droppedCount=4, entries pc of cycles 1..16.
//   4 full FIFO, outReady=1 while capturing -> one pop+push per edge, level stays 16, droppedCount unchanged.
//   5 assert rst mid-CAPTURE between edges -> outValid=0, level=0, busy=0 immediately, no clk needed.
//   6 clear and start on same edge in DONE with level=5 -> IDLE, level=0, overflow=0, no capture.

Source files
------------

// File: rtl/instruction_trace_buffer.sv
// rtl/instruction_trace_buffer.sv - retired pc/instruction capture FIFO with trigger, limit and stream drain
module instruction_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc,
    input  logic [31:0]       instruction,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              triggerEnable,
    input  logic [31:0]       triggerPc,
    input  logic [15:0]       captureLimit,
    output logic              outValid,
    input  logic              outReady,
    output logic [31:0]       outPc,
    output logic [31:0]       outInstr,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [15:0]       droppedCount,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [ADDR_W:0]   FULL_LEVEL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       dropped_q, dropped_d;
    logic [15:0]       accepted_q, accepted_d;

    logic [31:0] pc_mem_q    [DEPTH];
    logic [31:0] instr_mem_q [DEPTH];

    logic        pop;
    logic        trig_match;
    logic        push_req;
    logic        push_ok;
    logic        drop;
    logic        limit_hit;
    logic [15:0] accepted_inc;

    always_comb begin
        pop          = (level_q != '0) && outReady && !clear;
        trig_match   = (state_q == ST_ARMED) && (pc == triggerPc);
        push_req     = !clear && !stop && ((state_q == ST_CAPTURE) || trig_match);
        // A full FIFO still takes the push when the head leaves on the same edge
        push_ok      = push_req && ((level_q != FULL_LEVEL) || pop);
        drop         = push_req && !push_ok;
        accepted_inc = accepted_q + 16'd1;
        limit_hit    = push_ok && (captureLimit != 16'd0) && (accepted_inc == captureLimit);

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        accepted_d = accepted_q;

        if (clear) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            dropped_d  = '0;
            accepted_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d    = triggerEnable ? ST_ARMED : ST_CAPTURE;
                        accepted_d = '0;
                    end
                end
                ST_ARMED: begin
                    if (stop)            state_d = ST_DONE;
                    else if (trig_match) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (stop) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (limit_hit) state_d = ST_DONE;

            if (push_ok) begin
                wr_ptr_d   = wr_ptr_q + PTR_ONE;
                accepted_d = accepted_inc;
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

            if (push_ok && !pop)      level_d = level_q + LEVEL_ONE;
            else if (!push_ok && pop) level_d = level_q - LEVEL_ONE;

            if (drop) begin
                overflow_d = 1'b1;
                if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
            accepted_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
            accepted_q <= accepted_d;
        end
    end

    // Storage carries no reset; the outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem_q[wr_ptr_q]    <= pc;
            instr_mem_q[wr_ptr_q] <= instruction;
        end
    end

    assign outValid     = (level_q != '0);
    assign outPc        = outValid ? pc_mem_q[rd_ptr_q] : 32'd0;
    assign outInstr     = outValid ? instr_mem_q[rd_ptr_q] : 32'd0;
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign droppedCount = dropped_q;
    assign busy         = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_instruction_trace_buffer.sv
// tb/tb_instruction_trace_buffer.sv - scoreboard bench for instruction_trace_buffer
module tb_instruction_trace_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        start;
    logic        stop;
    logic        clear;
    logic        triggerEnable;
    logic [31:0] triggerPc;
    logic [15:0] captureLimit;
    logic        outValid;
    logic        outReady;
    logic [31:0] outPc;
    logic [31:0] outInstr;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] droppedCount;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_e;

    instruction_trace_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
        .start(start), .stop(stop), .clear(clear),
        .triggerEnable(triggerEnable), .triggerPc(triggerPc), .captureLimit(captureLimit),
        .outValid(outValid), .outReady(outReady), .outPc(outPc), .outInstr(outInstr),
        .level(level), .overflow(overflow), .droppedCount(droppedCount), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] p);
        return p ^ 32'hDEAD_0013;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] p);
        pc          = p;
        instruction = instr_of(p);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; stop = 0; clear = 0; triggerEnable = 0;
        triggerPc = 0; captureLimit = 0; outReady = 0; set_pc(32'h0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if (outValid !== 1'b0 || level !== 5'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: valid=%b level=%0d busy=%b, want 0 0 0", outValid, level, busy);
        end
        checks++;
        if (overflow !== 1'b0 || droppedCount !== 16'd0 || outPc !== 32'd0 || outInstr !== 32'd0) begin
            failures++;
            $display("FAIL reset_data: ovf=%b drop=%0d pc=%h instr=%h, want all 0", overflow, droppedCount, outPc, outInstr);
        end
    endtask

    task automatic test_limit();
        triggerEnable = 0; captureLimit = 16'd3; start = 1; set_pc(32'hFFF0);
        cyc();
        start = 0;
        for (int i = 0; i < 4; i++) begin
            set_pc(32'(i * 4));
            if (i < 3) sb.push_back({32'(i * 4), instr_of(32'(i * 4))});
            cyc();
        end
        checks++;
        if (level !== 5'd3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL limit_level: level=%0d busy=%b, want 3 0", level, busy);
        end
        outReady = 1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            if (outValid) begin
                exp_e = sb.pop_front();
                checks++;
                if (outPc !== exp_e[63:32] || outInstr !== exp_e[31:0]) begin
                    failures++;
                    $display("FAIL limit_entry: got %h/%h want %h/%h", outPc, outInstr, exp_e[63:32], exp_e[31:0]);
                end
            end
            cyc();
        end
        outReady = 0;
        checks++;
        if (sb.size() != 0 || level !== 5'd0) begin
            failures++;
            $display("FAIL limit_drain: left=%0d level=%0d, want 0 0", sb.size(), level);
        end
    endtask

    task automatic test_trigger();
        triggerEnable = 1; triggerPc = 32'h10; captureLimit = 0; start = 1; set_pc(32'hFFF0);
        cyc();
        start = 0;
        checks++;
        if (busy !== 1'b1 || level !== 5'd0) begin
            failures++;
            $display("FAIL trig_armed: busy=%b level=%0d, want 1 0", busy, level);
        end
        for (int p = 0; p < 32'h20; p += 4) begin
            set_pc(32'(p));
            if (p >= 32'h10) sb.push_back({32'(p), instr_of(32'(p))});
            cyc();
        end
        checks++;
        if (busy !== 1'b1 || level !== 5'd4) begin
            failures++;
            $display("FAIL trig_capture: busy=%b level=%0d, want 1 4", busy, level);
        end
        stop = 1; set_pc(32'h20);
        cyc();
        stop = 0;
        checks++;
        if (busy !== 1'b0 || level !== 5'd4) begin
            failures++;
            $display("FAIL trig_stop: busy=%b level=%0d, want 0 4", busy, level);
        end
        outReady = 1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            if (outValid) begin
                exp_e = sb.pop_front();
                checks++;
                if (outPc !== exp_e[63:32] || outInstr !== exp_e[31:0]) begin
                    failures++;
                    $display("FAIL trig_entry: got %h/%h want %h/%h", outPc, outInstr, exp_e[63:32], exp_e[31:0]);
                end
            end
            cyc();
        end
        outReady = 0;
        checks++;
        if (sb.size() != 0 || level !== 5'd0) begin
            failures++;
            $display("FAIL trig_drain: left=%0d level=%0d, want 0 0", sb.size(), level);
        end
    endtask

    task automatic test_overflow();
        triggerEnable = 0; captureLimit = 0; outReady = 0; start = 1; set_pc(32'hFFF0);
        cyc();
        start = 0;
        for (int i = 0; i < 20; i++) begin
            set_pc(32'h100 + 32'(i * 4));
            if (i < 16) sb.push_back({32'h100 + 32'(i * 4), instr_of(32'h100 + 32'(i * 4))});
            cyc();
        end
        checks++;
        if (level !== 5'd16 || overflow !== 1'b1 || droppedCount !== 16'd4 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ovf_state: level=%0d ovf=%b drop=%0d busy=%b, want 16 1 4 1", level, overflow, droppedCount, busy);
        end
        stop = 1;
        cyc();
        stop = 0;
        checks++;
        if (droppedCount !== 16'd4 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ovf_stop: drop=%0d busy=%b, want 4 0", droppedCount, busy);
        end
    endtask

    task automatic test_back_to_back();
        start = 1; set_pc(32'hFFF0);
        cyc();
        start = 0;
        outReady = 1;
        for (int i = 0; i < 8; i++) begin
            set_pc(32'h200 + 32'(i * 4));
            exp_e = sb.pop_front();
            checks++;
            if (outValid !== 1'b1 || outPc !== exp_e[63:32] || outInstr !== exp_e[31:0]) begin
                failures++;
                $display("FAIL b2b_head: valid=%b got %h/%h want %h/%h", outValid, outPc, outInstr, exp_e[63:32], exp_e[31:0]);
            end
            sb.push_back({32'h200 + 32'(i * 4), instr_of(32'h200 + 32'(i * 4))});
            cyc();
            checks++;
            if (level !== 5'd16 || droppedCount !== 16'd4) begin
                failures++;
                $display("FAIL b2b_level: level=%0d drop=%0d, want 16 4", level, droppedCount);
            end
        end
        outReady = 0; stop = 1;
        cyc();
        stop = 0;
        outReady = 1;
        for (int i = 0; i < 60 && sb.size() > 0; i++) begin
            if (outValid) begin
                exp_e = sb.pop_front();
                checks++;
                if (outPc !== exp_e[63:32] || outInstr !== exp_e[31:0]) begin
                    failures++;
                    $display("FAIL b2b_entry: got %h/%h want %h/%h", outPc, outInstr, exp_e[63:32], exp_e[31:0]);
                end
            end
            cyc();
        end
        outReady = 0;
        checks++;
        if (sb.size() != 0 || level !== 5'd0) begin
            failures++;
            $display("FAIL b2b_drain: left=%0d level=%0d, want 0 0", sb.size(), level);
        end
    endtask

    task automatic test_reset_mid();
        triggerEnable = 0; captureLimit = 0; start = 1;
        cyc();
        start = 0;
        for (int i = 0; i < 3; i++) begin
            set_pc(32'h300 + 32'(i * 4));
            cyc();
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (outValid !== 1'b0 || level !== 5'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: valid=%b level=%0d busy=%b, want 0 0 0", outValid, level, busy);
        end
        sb.delete();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_clear_start();
        triggerEnable = 0; captureLimit = 16'd5; start = 1;
        cyc();
        start = 0;
        for (int i = 0; i < 6; i++) begin
            set_pc(32'h400 + 32'(i * 4));
            cyc();
        end
        checks++;
        if (level !== 5'd5 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_setup: level=%0d busy=%b, want 5 0", level, busy);
        end
        clear = 1; start = 1;
        cyc();
        clear = 0; start = 0;
        checks++;
        if (level !== 5'd0 || outValid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_state: level=%0d valid=%b ovf=%b busy=%b, want 0 0 0 0", level, outValid, overflow, busy);
        end
        for (int i = 0; i < 3; i++) begin
            set_pc(32'h500 + 32'(i * 4));
            cyc();
        end
        checks++;
        if (level !== 5'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_idle: level=%0d busy=%b, want 0 0", level, busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_limit();
        test_trigger();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_clear_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
